// File: rtl/tdm_mux_scanner_if.sv
// Bus bundle for tdm_mux_scanner: controls and packed channel data in, tagged sample out.
// The master side drives controls and data; the slave side (the scanner) drives the outputs.
interface tdm_mux_scanner_if #(
  parameter int N_CH = 4,
  parameter int W    = 1
);
  localparam int SEL_W = ($clog2(N_CH) < 1) ? 1 : $clog2(N_CH);

  logic              en;
  logic              mode;
  logic [SEL_W-1:0]  sel_in;
  logic [N_CH*W-1:0] din;
  logic [W-1:0]      dout;
  logic [SEL_W-1:0]  ch_out;
  logic              valid;
  logic              frame;

  modport master (
    output en, mode, sel_in, din,
    input  dout, ch_out, valid, frame
  );

  modport slave (
    input  en, mode, sel_in, din,
    output dout, ch_out, valid, frame
  );
endinterface

// File: rtl/tdm_mux_scanner.sv
// N-channel registered mux with manual select or auto-rotating scan (DWELL cycles per channel).
// One cycle din->dout; en=0 freezes the scan position and drops valid.
module tdm_mux_scanner #(
  parameter int N_CH  = 4,
  parameter int W     = 1,
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              rst,
  tdm_mux_scanner_if.slave  bus
);
  localparam int SEL_W = ($clog2(N_CH) < 1) ? 1 : $clog2(N_CH);
  localparam int CNT_W = ($clog2(DWELL) < 1) ? 1 : $clog2(DWELL);

  typedef enum logic [1:0] {IDLE, MAN, SCAN} state_t;

  state_t           r_state;
  state_t           w_nxt;
  logic [SEL_W-1:0] r_ch;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;
  logic [W-1:0]     r_dout;
  logic [SEL_W-1:0] r_ch_out;
  logic             r_valid;
  logic             r_frame;

  logic [SEL_W-1:0] w_idx;
  logic [CNT_W-1:0] w_cnt;
  logic [W-1:0]     w_mux;
  logic             w_ld;
  logic             w_vld;
  logic             w_frm;
  logic             w_last;
  logic             w_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = IDLE;
    if (bus.en) w_nxt = bus.mode ? SCAN : MAN;
  end

  // Outputs follow the state being entered, so mode changes act on the same edge.
  always_comb begin
    w_idx  = r_ch_out;
    w_cnt  = r_cnt;
    w_ld   = 1'b0;
    w_vld  = 1'b0;
    w_frm  = 1'b0;
    w_last = 1'b0;
    w_wrap = 1'b0;
    case (w_nxt)
      MAN: begin
        w_idx = bus.sel_in;
        w_vld = int'(bus.sel_in) < N_CH;
        w_ld  = w_vld;
      end
      SCAN: begin
        w_idx  = (r_state == MAN) ? '0 : r_ch;
        w_cnt  = (r_state == MAN) ? '0 : r_cnt;
        w_ld   = 1'b1;
        w_vld  = 1'b1;
        w_frm  = r_pend && (r_state != MAN) && (r_ch == '0) && (r_cnt == '0);
        w_last = (w_cnt == CNT_W'(DWELL - 1));
        w_wrap = w_last && (w_idx == SEL_W'(N_CH - 1));
      end
      default: ;
    endcase
  end

  always_comb begin
    w_mux = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (w_idx == SEL_W'(k)) w_mux = bus.din[k*W +: W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout   <= '0;
      r_ch_out <= '0;
      r_valid  <= 1'b0;
      r_frame  <= 1'b0;
      r_ch     <= '0;
      r_cnt    <= '0;
      r_pend   <= 1'b0;
    end else begin
      if (w_ld) begin
        r_dout   <= w_mux;
        r_ch_out <= w_idx;
      end
      r_valid <= w_vld;
      r_frame <= w_frm;
      case (w_nxt)
        MAN: begin
          r_ch   <= '0;
          r_cnt  <= '0;
          r_pend <= 1'b0;
        end
        SCAN: begin
          if (w_last) begin
            r_cnt <= '0;
            r_ch  <= (w_idx == SEL_W'(N_CH - 1)) ? '0 : w_idx + 1'b1;
          end else begin
            r_cnt <= w_cnt + 1'b1;
          end
          // r_pend remembers a wrap until channel 0 is actually presented.
          if (w_wrap)     r_pend <= 1'b1;
          else if (w_frm) r_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.dout   = r_dout;
  assign bus.ch_out = r_ch_out;
  assign bus.valid  = r_valid;
  assign bus.frame  = r_frame;
endmodule
